// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch stage: instruction-memory port, redirect input and
// the decode-side instruction stream. The master modport is the fetch unit.
//
// Handshakes:
//  - Memory: oIMemReq is a one-cycle pulse carrying oIMemAddr. At most one read
//    is outstanding. The memory answers with a one-cycle iIMemAck carrying
//    iIMemData, no earlier than the cycle after the request.
//  - Decode: an instruction moves to decode in every cycle where oValid and
//    iReady are both high. oValid never depends on iReady. While oValid is low,
//    oInstr/oPC/oOp/oFunct are zero.
//  - Redirect: iRedirect takes priority over any memory or decode transfer in
//    the same cycle.
interface instr_fetch_unit_if;
   logic        oIMemReq;
   logic [31:0] oIMemAddr;
   logic        iIMemAck;
   logic [31:0] iIMemData;
   logic        iRedirect;
   logic [31:0] iRedirectPC;
   logic        oValid;
   logic        iReady;
   logic [31:0] oInstr;
   logic [31:0] oPC;
   logic [5:0]  oOp;
   logic [5:0]  oFunct;

   modport master (
      output oIMemReq, oIMemAddr, oValid, oInstr, oPC, oOp, oFunct,
      input  iIMemAck, iIMemData, iRedirect, iRedirectPC, iReady
   );

   modport slave (
      input  oIMemReq, oIMemAddr, oValid, oInstr, oPC, oOp, oFunct,
      output iIMemAck, iIMemData, iRedirect, iRedirectPC, iReady
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the fetch PC, issues single outstanding word reads,
// buffers returned words in a small FIFO and presents the head to decode.
// The head word/PC/valid are registers loaded with the next-cycle head, so the
// decode side sees only flop outputs.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                iClk,
   input  logic                iReset,
   instr_fetch_unit_if.master  bus,
   output logic [1:0]          oFsmState
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   // IDLE: may request; WAIT: read in flight; DROP: read in flight, data stale
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t            state;
   logic [31:0]       fetchPC;
   logic [31:0]       redirectPC;

   logic [31:0]       bufInstr [FIFO_DEPTH];
   logic [31:0]       bufPC    [FIFO_DEPTH];
   logic [PTR_W-1:0]  rdPtr;
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  nextRdPtr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  nextCount;

   logic              headValid;
   logic [31:0]       headInstr;
   logic [31:0]       headPC;
   logic [31:0]       nextHeadInstr;
   logic [31:0]       nextHeadPC;

   logic              reqNow;
   logic              push;
   logic              pop;

   // Low two bits of the redirect target are forced to zero (word fetch)
   assign redirectPC = bus.iRedirectPC & 32'hFFFF_FFFC;

   // Request/transfer qualifiers; redirect and reset suppress everything
   always_comb begin
      reqNow = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
      if (!iReset) begin
         reqNow = (state == IDLE) && (count < CNT_W'(FIFO_DEPTH)) && !bus.iRedirect;
         push   = (state == WAIT) && bus.iIMemAck && !bus.iRedirect;
         pop    = headValid && bus.iReady && !bus.iRedirect;
      end
   end

   // Next read pointer, occupancy and the head entry visible next cycle
   always_comb begin
      nextRdPtr = rdPtr;
      if (pop) begin
         nextRdPtr = rdPtr + 1'b1;
      end
      nextCount     = count + CNT_W'(push) - CNT_W'(pop);
      nextHeadInstr = '0;
      nextHeadPC    = '0;
      if (nextCount != '0) begin
         // A word pushed into the slot that becomes the head is not in storage yet
         if (push && (wrPtr == nextRdPtr)) begin
            nextHeadInstr = bus.iIMemData;
            nextHeadPC    = fetchPC;
         end else begin
            nextHeadInstr = bufInstr[nextRdPtr];
            nextHeadPC    = bufPC[nextRdPtr];
         end
      end
   end

   // Fetch FSM and fetch PC
   always_ff @(posedge iClk) begin
      if (iReset) begin
         state   <= IDLE;
         fetchPC <= RESET_PC;
      end else begin
         case (state)
            IDLE: begin
               if (bus.iRedirect) begin
                  fetchPC <= redirectPC;
               end else if (reqNow) begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (bus.iRedirect) begin
                  fetchPC <= redirectPC;
                  state   <= bus.iIMemAck ? IDLE : DROP;
               end else if (bus.iIMemAck) begin
                  fetchPC <= fetchPC + 32'd4;
                  state   <= IDLE;
               end
            end
            DROP: begin
               // The stale read still completes; only then can a new one start
               if (bus.iRedirect) begin
                  fetchPC <= redirectPC;
               end
               if (bus.iIMemAck) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // FIFO pointers, occupancy and registered head; redirect flushes
   always_ff @(posedge iClk) begin
      if (iReset || bus.iRedirect) begin
         rdPtr     <= '0;
         wrPtr     <= '0;
         count     <= '0;
         headValid <= 1'b0;
         headInstr <= '0;
         headPC    <= '0;
      end else begin
         rdPtr     <= nextRdPtr;
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         count     <= nextCount;
         headValid <= (nextCount != '0);
         headInstr <= nextHeadInstr;
         headPC    <= nextHeadPC;
      end
   end

   // FIFO storage write (contents are don't-care until counted)
   always_ff @(posedge iClk) begin
      if (push) begin
         bufInstr[wrPtr] <= bus.iIMemData;
         bufPC[wrPtr]    <= fetchPC;
      end
   end

   assign bus.oIMemReq  = reqNow;
   assign bus.oIMemAddr = (reqNow || (state == WAIT)) ? fetchPC : 32'h0;
   assign bus.oValid    = headValid;
   assign bus.oInstr    = headInstr;
   assign bus.oPC       = headPC;
   assign bus.oOp       = headInstr[31:26];
   assign bus.oFunct    = headInstr[5:0];
   assign oFsmState     = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a stream-level model of the fetch stage (expected
// buffered PCs, one outstanding read, stale-read tracking) checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] fsm_state;

   always #5 clk = ~clk;

   instr_fetch_unit_if bus();

   instr_fetch_unit #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .iClk      (clk),
      .iReset    (rst),
      .bus       (bus),
      .oFsmState (fsm_state)
   );

   // ---------------- bench state ----------------
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // driver settings for the next cycle
   bit          drv_rst      = 1'b1;
   bit          drv_ready    = 1'b0;
   bit          drv_redir    = 1'b0;
   logic [31:0] drv_redir_pc = '0;
   int          lat_cfg      = 1;   // 0 = random latency 1..3

   // memory responder
   bit          mem_pend = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_lat  = 0;

   // behavioural model: PCs of buffered words, outstanding read, next fetch PC
   logic [31:0] exp_q[$];
   bit          model_out      = 1'b0;
   bit          model_stale    = 1'b0;
   logic [31:0] model_out_pc   = '0;
   logic [31:0] model_fetch_pc = RESET_PC;

   // logs for literal checks
   logic [31:0] req_log[$];
   int          req_cyc[$];
   logic [31:0] pop_log[$];
   int          pop_cyc[$];
   logic [5:0]  pop_op[$];
   logic [5:0]  pop_funct[$];

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_req(input string name, input int i, input logic [31:0] addr, input int c);
      if (req_log.size() > i) begin
         chk({name, "_addr"}, req_log[i], addr);
         chk({name, "_cyc"}, req_cyc[i], c);
      end else begin
         total++;
         bad++;
         $display("FAIL %s: only %0d requests seen, required index %0d", name, req_log.size(), i);
      end
   endtask

   task automatic chk_pop(input string name, input int i, input logic [31:0] pc, input int c);
      if (pop_log.size() > i) begin
         chk({name, "_pc"}, pop_log[i], pc);
         chk({name, "_cyc"}, pop_cyc[i], c);
      end else begin
         total++;
         bad++;
         $display("FAIL %s: only %0d pops seen, required index %0d", name, pop_log.size(), i);
      end
   endtask

   // per-cycle compare against the model, then advance the model
   task automatic check_and_update();
      logic        exp_req;
      logic [31:0] w;
      exp_req = !rst && !model_out && (exp_q.size() < DEPTH) && !bus.iRedirect;
      if (chk_en) begin
         chk("req", bus.oIMemReq, exp_req);
         if (bus.oIMemReq && exp_req) chk("req_addr", bus.oIMemAddr, model_fetch_pc);
         chk("valid", bus.oValid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            w = mem_word(exp_q[0]);
            chk("pc", bus.oPC, exp_q[0]);
            chk("instr", bus.oInstr, w);
            chk("op", bus.oOp, w[31:26]);
            chk("funct", bus.oFunct, w[5:0]);
         end else begin
            chk("pc_empty", bus.oPC, 32'h0);
            chk("instr_empty", bus.oInstr, 32'h0);
            chk("op_empty", bus.oOp, 6'h0);
            chk("funct_empty", bus.oFunct, 6'h0);
         end
      end
      if (bus.oIMemReq && !rst) begin
         req_log.push_back(bus.oIMemAddr);
         req_cyc.push_back(cyc);
         mem_pend = 1'b1;
         mem_addr = bus.oIMemAddr;
         mem_lat  = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 3));
      end
      if (rst) begin
         exp_q.delete();
         model_out      = 1'b0;
         model_stale    = 1'b0;
         model_fetch_pc = RESET_PC;
      end else begin
         if (exp_q.size() != 0 && bus.iReady && !bus.iRedirect) begin
            pop_log.push_back(bus.oPC);
            pop_cyc.push_back(cyc);
            pop_op.push_back(bus.oOp);
            pop_funct.push_back(bus.oFunct);
            void'(exp_q.pop_front());
         end
         if (bus.iRedirect) begin
            exp_q.delete();
            model_fetch_pc = bus.iRedirectPC & 32'hFFFF_FFFC;
            if (model_out) begin
               if (bus.iIMemAck) begin
                  model_out   = 1'b0;
                  model_stale = 1'b0;
               end else begin
                  model_stale = 1'b1;
               end
            end
         end else if (bus.iIMemAck && model_out) begin
            if (!model_stale) begin
               exp_q.push_back(model_out_pc);
               model_fetch_pc = model_fetch_pc + 32'd4;
            end
            model_out   = 1'b0;
            model_stale = 1'b0;
         end
         if (exp_req) begin
            model_out    = 1'b1;
            model_out_pc = model_fetch_pc;
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
      rst             = drv_rst;
      bus.iReady      = drv_ready;
      bus.iRedirect   = drv_redir;
      bus.iRedirectPC = drv_redir_pc;
      bus.iIMemAck    = 1'b0;
      bus.iIMemData   = 32'hDEAD_BEEF;
      if (drv_rst) mem_pend = 1'b0;
      if (mem_pend) begin
         mem_lat--;
         if (mem_lat <= 0) begin
            bus.iIMemAck  = 1'b1;
            bus.iIMemData = mem_word(mem_addr);
            mem_pend      = 1'b0;
         end
      end
      @(negedge clk);
      check_and_update();
      cyc++;
   endtask

   task automatic do_reset();
      drv_rst   = 1'b1;
      drv_redir = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      chk("rst_valid", bus.oValid, 1'b0);
      chk("rst_req", bus.oIMemReq, 1'b0);
      chk("rst_pc", bus.oPC, 32'h0);
      chk("rst_instr", bus.oInstr, 32'h0);
      chk("rst_state", fsm_state, 2'd0);
      drv_rst = 1'b0;
      req_log.delete();
      req_cyc.delete();
      pop_log.delete();
      pop_cyc.delete();
      pop_op.delete();
      pop_funct.delete();
      cyc = 0;
   endtask

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scenarios ----------------
   initial begin
      bus.iReady      = 1'b0;
      bus.iRedirect   = 1'b0;
      bus.iRedirectPC = '0;
      bus.iIMemAck    = 1'b0;
      bus.iIMemData   = '0;

      // 1: sequential fetch with 1-cycle memory, decode always ready
      drv_ready = 1'b1;
      lat_cfg   = 1;
      do_reset();
      repeat (8) step();
      chk_req("seq_r0", 0, 32'h0, 0);
      chk_req("seq_r1", 1, 32'h4, 2);
      chk_req("seq_r2", 2, 32'h8, 4);
      chk_pop("seq_p0", 0, 32'h0, 2);
      chk_pop("seq_p1", 1, 32'h4, 4);
      chk_pop("seq_p2", 2, 32'h8, 6);
      if (pop_op.size() > 0) begin
         chk("seq_op0", pop_op[0], 6'h16);
         chk("seq_funct0", pop_funct[0], 6'h34);
      end else begin
         total++;
         bad++;
         $display("FAIL seq_op0: no instruction popped");
      end

      // 2: decode stalled, buffer fills to depth, then one pop releases a request
      drv_ready = 1'b0;
      do_reset();
      repeat (10) step();
      chk("stall_nreq", req_log.size(), 2);
      chk("stall_req_low", bus.oIMemReq, 1'b0);
      chk("stall_valid", bus.oValid, 1'b1);
      chk("stall_pc", bus.oPC, 32'h0);
      drv_ready = 1'b1;
      step();
      drv_ready = 1'b0;
      step();
      chk_pop("stall_p0", 0, 32'h0, 10);
      chk_req("stall_r2", 2, 32'h8, 11);

      // 3: redirect while a read is in flight; stale word returns later
      drv_ready = 1'b1;
      lat_cfg   = 4;
      do_reset();
      step();
      drv_redir    = 1'b1;
      drv_redir_pc = 32'h0000_0103;
      step();
      drv_redir = 1'b0;
      lat_cfg   = 1;
      repeat (8) step();
      chk_req("drop_r1", 1, 32'h100, 5);
      chk_pop("drop_p0", 0, 32'h100, 7);

      // 4: redirect and ack in the same cycle
      lat_cfg = 2;
      do_reset();
      step();
      step();
      drv_redir    = 1'b1;
      drv_redir_pc = 32'h0000_0200;
      step();
      drv_redir = 1'b0;
      lat_cfg   = 1;
      chk("same_valid", bus.oValid, 1'b0);
      repeat (6) step();
      chk_req("same_r1", 1, 32'h200, 3);
      chk_pop("same_p0", 0, 32'h200, 5);

      // 5: redirect to the top of the address space, fetch wraps to zero
      do_reset();
      drv_redir    = 1'b1;
      drv_redir_pc = 32'hFFFF_FFFF;
      step();
      drv_redir = 1'b0;
      repeat (8) step();
      chk_req("wrap_r0", 0, 32'hFFFF_FFFC, 1);
      chk_req("wrap_r1", 1, 32'h0, 3);
      chk_pop("wrap_p0", 0, 32'hFFFF_FFFC, 3);
      chk_pop("wrap_p1", 1, 32'h0, 5);

      // 6: reset while a read is in flight with a word buffered
      drv_ready = 1'b0;
      lat_cfg   = 3;
      do_reset();
      repeat (6) step();
      chk("mid_state_wait", fsm_state, 2'd1);
      chk("mid_valid_pre", bus.oValid, 1'b1);
      drv_rst = 1'b1;
      step();
      drv_rst = 1'b0;
      step();
      chk("mid_valid", bus.oValid, 1'b0);
      chk("mid_req", bus.oIMemReq, 1'b1);
      chk("mid_addr", bus.oIMemAddr, RESET_PC);

      // 7: randomized traffic
      lat_cfg = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drv_ready = ($urandom_range(0, 3) != 0);
         drv_redir = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) drv_redir_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         else drv_redir_pc = $urandom;
         drv_rst = ($urandom_range(0, 499) == 0);
         step();
      end
      drv_rst   = 1'b0;
      drv_redir = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
